regfile32: RTL and testbench

Register file of 32 general-purpose registers, written through a one-hot write-select vector and read through two combinational read ports. It sits directly downstream of the 5-to-32 write-address decoder in the CPU datapath and consumes that decoder's 32-bit one-hot output. Register 31 is the hardwired zero register. The block also tracks which registers have been written and flags illegal (multi-hot) write selects.

---
 rtl/regfile32.sv | 95 +++++++++
 tb/tb_regfile32.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile32.sv
// 32-entry register file with one-hot write select, two combinational read ports,
// per-register dirty tracking and a sticky multi-hot error flag.
// Define REGFILE32_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile32 #(
   parameter int DATA_W   = 64,
   parameter int ZERO_IDX = 31
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [31:0]       wr_sel,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [4:0]        rd_addr_a,
   input  logic [4:0]        rd_addr_b,
   output logic [DATA_W-1:0] rd_data_a,
   output logic [DATA_W-1:0] rd_data_b,
   output logic [31:0]       dirty,
   input  logic              dirty_clr,
   output logic              err_multi,
   input  logic              err_clr
);

   localparam logic [31:0] ZERO_MASK = 32'(1) << ZERO_IDX;
   localparam logic [4:0]  ZERO_ADDR = 5'(ZERO_IDX);

   logic [DATA_W-1:0] r_regs [32];
   logic [31:0]       r_dirty;
   logic              r_err_multi;

   logic              w_multi;
   logic [31:0]       w_wr_eff;
   logic [DATA_W-1:0] w_rd_a;
   logic [DATA_W-1:0] w_rd_b;

   // Clearing the lowest set bit leaves something only when two or more bits are set.
   assign w_multi  = |(wr_sel & (wr_sel - 32'd1));
   assign w_wr_eff = w_multi ? 32'h0 : (wr_sel & ~ZERO_MASK);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) begin
            r_regs[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 32; i++) begin
            if (w_wr_eff[i]) begin
               r_regs[i] <= wr_data;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dirty     <= 32'h0;
         r_err_multi <= 1'b0;
      end else begin
         r_dirty <= (dirty_clr ? 32'h0 : r_dirty) | w_wr_eff;
         if (w_multi) begin
            r_err_multi <= 1'b1;
         end else if (err_clr) begin
            r_err_multi <= 1'b0;
         end
      end
   end

   always_comb begin
      w_rd_a = r_regs[rd_addr_a];
`ifdef REGFILE32_BYPASS_EN
      if (w_wr_eff[rd_addr_a]) begin
         w_rd_a = wr_data;
      end
`endif
      if (rd_addr_a == ZERO_ADDR) begin
         w_rd_a = '0;
      end
   end

   always_comb begin
      w_rd_b = r_regs[rd_addr_b];
`ifdef REGFILE32_BYPASS_EN
      if (w_wr_eff[rd_addr_b]) begin
         w_rd_b = wr_data;
      end
`endif
      if (rd_addr_b == ZERO_ADDR) begin
         w_rd_b = '0;
      end
   end

   assign rd_data_a = w_rd_a;
   assign rd_data_b = w_rd_b;
   assign dirty     = r_dirty;
   assign err_multi = r_err_multi;

endmodule

// File: tb/tb_regfile32.sv
// Bench for regfile32: directed vector table, hand-written corner sequences and
// randomized traffic checked against an array-based reference model.
`timescale 1ns/1ps
module tb_regfile32;

   logic        clk;
   logic        rst_n;
   logic [31:0] wr_sel;
   logic [63:0] wr_data;
   logic [4:0]  rd_addr_a;
   logic [4:0]  rd_addr_b;
   logic [63:0] rd_data_a;
   logic [63:0] rd_data_b;
   logic [31:0] dirty;
   logic        dirty_clr;
   logic        err_multi;
   logic        err_clr;

   int n_pass  = 0;
   int n_total = 0;

   logic [63:0] mdl [32];
   logic [31:0] m_dirty;
   logic        m_err;

   typedef struct {
      logic [31:0] sel;
      logic [63:0] data;
      logic        dclr;
      logic        eclr;
      logic [4:0]  ra;
      logic [4:0]  rb;
      logic [63:0] ea;
      logic [63:0] eb;
      logic [31:0] edirty;
      logic        eerr;
   } vec_t;

   vec_t vt [11];

   regfile32 #(.DATA_W(64), .ZERO_IDX(31)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_sel    (wr_sel),
      .wr_data   (wr_data),
      .rd_addr_a (rd_addr_a),
      .rd_addr_b (rd_addr_b),
      .rd_data_a (rd_data_a),
      .rd_data_b (rd_data_b),
      .dirty     (dirty),
      .dirty_clr (dirty_clr),
      .err_multi (err_multi),
      .err_clr   (err_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] exp_rd(input logic [4:0] addr, input logic [31:0] sel,
                                          input logic [63:0] data);
      if (addr == 5'd31) return 64'h0;
`ifdef REGFILE32_BYPASS_EN
      if ($countones(sel) == 1 && sel[addr]) return data;
`endif
      return mdl[addr];
   endfunction

   task automatic model_edge(input logic [31:0] sel, input logic [63:0] data,
                             input logic dclr, input logic eclr);
      int n;
      n = $countones(sel);
      if (dclr) m_dirty = 32'h0;
      if (n == 1) begin
         for (int k = 0; k < 31; k++) begin
            if (sel[k]) begin
               mdl[k]     = data;
               m_dirty[k] = 1'b1;
            end
         end
      end
      if (n > 1) m_err = 1'b1;
      else if (eclr) m_err = 1'b0;
   endtask

   initial begin
      logic [63:0] exp_same;
      rst_n     = 1'b0;
      wr_sel    = 32'h0;
      wr_data   = 64'h0;
      rd_addr_a = 5'd0;
      rd_addr_b = 5'd0;
      dirty_clr = 1'b0;
      err_clr   = 1'b0;

      vt[0]  = '{32'h0000_0020, 64'hDEAD_BEEF_0123_4567, 1'b0, 1'b0, 5'd5, 5'd5,
                 64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567, 32'h0000_0020, 1'b0};
      vt[1]  = '{32'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 5'd31, 5'd31,
                 64'h0, 64'h0, 32'h0000_0020, 1'b0};
      vt[2]  = '{32'h0000_0006, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 5'd1, 5'd2,
                 64'h0, 64'h0, 32'h0000_0020, 1'b1};
      vt[3]  = '{32'h0, 64'h0, 1'b0, 1'b1, 5'd5, 5'd31,
                 64'hDEAD_BEEF_0123_4567, 64'h0, 32'h0000_0020, 1'b0};
      vt[4]  = '{32'h0000_0008, 64'h33, 1'b0, 1'b0, 5'd3, 5'd5,
                 64'h33, 64'hDEAD_BEEF_0123_4567, 32'h0000_0028, 1'b0};
      vt[5]  = '{32'h0000_0200, 64'h99, 1'b1, 1'b0, 5'd9, 5'd3,
                 64'h99, 64'h33, 32'h0000_0200, 1'b0};
      vt[6]  = '{32'h0000_0300, 64'h77, 1'b0, 1'b1, 5'd9, 5'd8,
                 64'h99, 64'h0, 32'h0000_0200, 1'b1};
      vt[7]  = '{32'h0, 64'h0, 1'b0, 1'b1, 5'd8, 5'd9,
                 64'h0, 64'h99, 32'h0000_0200, 1'b0};
      vt[8]  = '{32'h0000_0003, 64'h5, 1'b1, 1'b0, 5'd0, 5'd1,
                 64'h0, 64'h0, 32'h0, 1'b1};
      vt[9]  = '{32'h8000_0001, 64'h6, 1'b0, 1'b0, 5'd0, 5'd31,
                 64'h0, 64'h0, 32'h0, 1'b1};
      vt[10] = '{32'h0000_0001, 64'hA5, 1'b0, 1'b1, 5'd0, 5'd0,
                 64'hA5, 64'hA5, 32'h0000_0001, 1'b0};

      #12;
      rst_n = 1'b1;
      for (int i = 0; i < 32; i++) begin
         rd_addr_a = 5'(i);
         rd_addr_b = 5'(31 - i);
         #1;
         chk($sformatf("reset_rd_a[%0d]", i), rd_data_a, 64'h0);
         chk($sformatf("reset_rd_b[%0d]", 31 - i), rd_data_b, 64'h0);
      end
      chk("reset_dirty", {32'h0, dirty}, 64'h0);
      chk("reset_err", {63'h0, err_multi}, 64'h0);
      tick();

      for (int i = 0; i < 11; i++) begin
         wr_sel    = vt[i].sel;
         wr_data   = vt[i].data;
         dirty_clr = vt[i].dclr;
         err_clr   = vt[i].eclr;
         rd_addr_a = vt[i].ra;
         rd_addr_b = vt[i].rb;
         tick();
         wr_sel    = 32'h0;
         dirty_clr = 1'b0;
         err_clr   = 1'b0;
         #1;
         chk($sformatf("vec%0d_rd_a", i), rd_data_a, vt[i].ea);
         chk($sformatf("vec%0d_rd_b", i), rd_data_b, vt[i].eb);
         chk($sformatf("vec%0d_dirty", i), {32'h0, dirty}, {32'h0, vt[i].edirty});
         chk($sformatf("vec%0d_err", i), {63'h0, err_multi}, {63'h0, vt[i].eerr});
      end

      // Read-during-write on register 7
      wr_sel  = 32'h0000_0080;
      wr_data = 64'h11;
      tick();
      wr_data   = 64'h55;
      rd_addr_a = 5'd7;
      rd_addr_b = 5'd7;
      #1;
`ifdef REGFILE32_BYPASS_EN
      exp_same = 64'h55;
`else
      exp_same = 64'h11;
`endif
      chk("rdw_same_cycle_a", rd_data_a, exp_same);
      chk("rdw_same_cycle_b", rd_data_b, exp_same);
      tick();
      wr_sel = 32'h0;
      #1;
      chk("rdw_next_cycle", rd_data_a, 64'h55);

      // Zero-register and multi-hot writes are never forwarded
      wr_sel    = 32'h8000_0000;
      wr_data   = 64'hFFFF_FFFF_FFFF_FFFF;
      rd_addr_a = 5'd31;
      #1;
      chk("zero_no_fwd", rd_data_a, 64'h0);
      wr_sel    = 32'h0000_0180;
      wr_data   = 64'hCAFE;
      rd_addr_a = 5'd7;
      rd_addr_b = 5'd8;
      #1;
      chk("multi_no_fwd_a", rd_data_a, 64'h55);
      chk("multi_no_fwd_b", rd_data_b, 64'h0);
      tick();
      wr_sel = 32'h0;
      chk("multi_err_set", {63'h0, err_multi}, 64'h1);
      chk("multi_reg7_kept", rd_data_a, 64'h55);

      // Asynchronous reset asserted mid-cycle
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_dirty", {32'h0, dirty}, 64'h0);
      chk("async_rst_err", {63'h0, err_multi}, 64'h0);
      chk("async_rst_rd_a", rd_data_a, 64'h0);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 32; i++) mdl[i] = 64'h0;
      m_dirty = 32'h0;
      m_err   = 1'b0;
      for (int it = 0; it < 400; it++) begin
         int kind;
         int a;
         int b;
         kind = $urandom_range(0, 9);
         if (kind < 2) begin
            wr_sel = 32'h0;
         end else if (kind < 8) begin
            wr_sel = 32'(1) << $urandom_range(0, 31);
         end else begin
            a = $urandom_range(0, 31);
            b = (a + $urandom_range(1, 31)) % 32;
            wr_sel = (32'(1) << a) | (32'(1) << b);
         end
         wr_data   = {$urandom, $urandom};
         dirty_clr = ($urandom_range(0, 9) == 0);
         err_clr   = ($urandom_range(0, 6) == 0);
         rd_addr_a = 5'($urandom_range(0, 31));
         rd_addr_b = (it % 4 == 0) ? rd_addr_a : 5'($urandom_range(0, 31));
         #1;
         chk("rnd_rd_a", rd_data_a, exp_rd(rd_addr_a, wr_sel, wr_data));
         chk("rnd_rd_b", rd_data_b, exp_rd(rd_addr_b, wr_sel, wr_data));
         model_edge(wr_sel, wr_data, dirty_clr, err_clr);
         tick();
         chk("rnd_dirty", {32'h0, dirty}, {32'h0, m_dirty});
         chk("rnd_err", {63'h0, err_multi}, {63'h0, m_err});
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
